// File: rtl/sram_like_mem_responder.sv
// Word-addressed RAM responder for a split instruction/data request interface.
// Optional per-request random extra latency is enabled by defining SRAM_LIKE_RESP_RAND_LAT_EN.
module sram_like_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  input  logic        longest_stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = 5;
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [0:DEPTH-1];

  logic [1:0]        inst_state_q, inst_state_d;
  logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
  logic [ADDR_W-1:0] inst_idx_q, inst_idx_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;

  logic [1:0]        data_state_q, data_state_d;
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
  logic [ADDR_W-1:0] data_idx_q, data_idx_d;
  logic [3:0]        data_wen_q, data_wen_d;
  logic [31:0]       data_wdata_q, data_wdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic [CNT_W-1:0]  lat_load;
  logic              inst_ready, data_ready;
  logic              inst_grant, data_grant;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       mem_rd;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                              data_addr[31:ADDR_W+2], data_addr[1:0]};

`ifdef SRAM_LIKE_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_load = CNT_W'(LATENCY);
`endif

  // A port is ready on the cycle its counter reaches zero (or is parked at zero).
  assign inst_ready = (inst_state_q == S_WAIT) && (inst_cnt_q <= CNT_W'(1));
  assign data_ready = (data_state_q == S_WAIT) && (data_cnt_q <= CNT_W'(1));
  assign data_grant = data_ready;
  assign inst_grant = inst_ready && !data_ready;

  assign acc_idx = data_grant ? data_idx_q : inst_idx_q;
  assign mem_rd  = mem_q[acc_idx];

  assign inst_stall = inst_en && (inst_state_q != S_DONE);
  assign data_stall = data_en && (data_state_q != S_DONE);
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  always_comb begin
    inst_state_d = inst_state_q;
    inst_cnt_d   = inst_cnt_q;
    inst_idx_d   = inst_idx_q;
    inst_rdata_d = inst_rdata_q;
    case (inst_state_q)
      S_IDLE: begin
        if (inst_en) begin
          inst_idx_d   = inst_addr[ADDR_W+1:2];
          inst_cnt_d   = lat_load;
          inst_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_cnt_q != '0) inst_cnt_d = inst_cnt_q - CNT_W'(1);
        if (inst_grant) begin
          inst_rdata_d = mem_rd;
          inst_state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!longest_stall) inst_state_d = S_IDLE;
      end
      default: inst_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_state_d = data_state_q;
    data_cnt_d   = data_cnt_q;
    data_idx_d   = data_idx_q;
    data_wen_d   = data_wen_q;
    data_wdata_d = data_wdata_q;
    data_rdata_d = data_rdata_q;
    case (data_state_q)
      S_IDLE: begin
        if (data_en) begin
          data_idx_d   = data_addr[ADDR_W+1:2];
          data_wen_d   = data_wen;
          data_wdata_d = data_wdata;
          data_cnt_d   = lat_load;
          data_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_cnt_q != '0) data_cnt_d = data_cnt_q - CNT_W'(1);
        if (data_grant) begin
          if (data_wen_q == 4'b0000) data_rdata_d = mem_rd;
          data_state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!longest_stall) data_state_d = S_IDLE;
      end
      default: data_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_state_q <= S_IDLE;
      inst_cnt_q   <= '0;
      inst_idx_q   <= '0;
      inst_rdata_q <= '0;
      data_state_q <= S_IDLE;
      data_cnt_q   <= '0;
      data_idx_q   <= '0;
      data_wen_q   <= '0;
      data_wdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      inst_state_q <= inst_state_d;
      inst_cnt_q   <= inst_cnt_d;
      inst_idx_q   <= inst_idx_d;
      inst_rdata_q <= inst_rdata_d;
      data_state_q <= data_state_d;
      data_cnt_q   <= data_cnt_d;
      data_idx_q   <= data_idx_d;
      data_wen_q   <= data_wen_d;
      data_wdata_q <= data_wdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Array contents are deliberately not reset; a reset clears data_grant so no write lands.
  always_ff @(posedge clk) begin
    if (data_grant) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wen_q[b]) mem_q[data_idx_q][8*b +: 8] <= data_wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Scoreboard bench for sram_like_mem_responder: latency, byte writes, conflicts, hold, flush, reset.
module tb_sram_like_mem_responder;
  localparam int ADDR_W = 12;
  localparam int LAT    = 2;
`ifdef SRAM_LIKE_RESP_RAND_LAT_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        longest_stall;
  logic        ls_force = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model [int];
  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_data_q [$];

  assign longest_stall = ls_force | inst_stall | data_stall;

  always #5 clk = ~clk;

  sram_like_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall), .longest_stall(longest_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  // Stall-cycle count: exact without random latency, bounded range with it.
  task automatic check_lat(input string tag, input int c, input int slack);
`ifdef SRAM_LIKE_RESP_RAND_LAT_EN
    check_eq(tag, {31'd0, (c >= LAT + 1) && (c <= LAT + 1 + EXTRA + slack)}, 32'd1);
`else
    check_eq(tag, c, LAT + 1 + slack);
`endif
  endtask

  // Entered just after a rising edge; returns just after a rising edge with enables dropped.
  task automatic run_req(input bit ie, input logic [31:0] ia, input bit de, input logic [3:0] wen,
                         input logic [31:0] da, input logic [31:0] wd, input int hold,
                         output int ci, output int cd);
    logic [31:0] w;
    logic [31:0] exp_d;
    exp_d = '0;
    if (de) begin
      if (wen == 4'b0000) exp_data_q.push_back(model[midx(da)]);
      else begin
        w = model.exists(midx(da)) ? model[midx(da)] : 32'h0;
        for (int b = 0; b < 4; b++) if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
        model[midx(da)] = w;
      end
    end
    if (ie) exp_inst_q.push_back(model[midx(ia)]);
    inst_en = ie; inst_addr = ia;
    data_en = de; data_wen = wen; data_addr = da; data_wdata = wd;
    ls_force = (hold > 0);
    ci = -1; cd = -1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && ie) check_eq("inst_stall_c0", inst_stall, 1);
      if (cyc == 0 && de) check_eq("data_stall_c0", data_stall, 1);
      if (ie && ci < 0 && !inst_stall) begin
        ci = cyc;
        check_eq("inst_rdata", inst_rdata, exp_inst_q.pop_front());
      end
      if (de && cd < 0 && !data_stall) begin
        cd = cyc;
        if (wen == 4'b0000) begin
          exp_d = exp_data_q.pop_front();
          check_eq("data_rdata", data_rdata, exp_d);
        end
      end
      if ((!ie || ci >= 0) && (!de || cd >= 0)) break;
      @(posedge clk); #1;
    end
    if ((ie && ci < 0) || (de && cd < 0)) begin
      check_eq("timeout", 0, 1);
      exp_inst_q.delete();
      exp_data_q.delete();
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("hold_stall", data_stall, 0);
      check_eq("hold_rdata", data_rdata, exp_d);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      ls_force = 1'b0;
    end
    @(posedge clk); #1;
    inst_en = 1'b0; data_en = 1'b0;
    $display("txn ie=%0b ia=%h de=%0b wen=%h da=%h wd=%h inst_cyc=%0d data_cyc=%0d",
             ie, ia, de, wen, da, wd, ci, cd);
  endtask

  initial begin
    int ci, cd;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_inst_rdata", inst_rdata, 32'h0);
    check_eq("rst_data_rdata", data_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_inst_stall", inst_stall, 0);
    check_eq("idle_data_stall", data_stall, 0);
    @(posedge clk); #1;

    // Preload and single fetch
    run_req(0, 0, 1, 4'hF, 32'h400, 32'hDEADBEEF, 0, ci, cd);
    check_lat("preload_lat", cd, 0);
    run_req(1, 32'h400, 0, 4'h0, 0, 0, 0, ci, cd);
    check_lat("single_read_lat", ci, 0);

    // Byte-lane write over a known word
    run_req(0, 0, 1, 4'hF, 32'h8, 32'hAAAAAAAA, 0, ci, cd);
    run_req(0, 0, 1, 4'b0011, 32'h8, 32'h12345678, 0, ci, cd);
    run_req(0, 0, 1, 4'h0, 32'h8, 0, 0, ci, cd);
    check_lat("byte_read_lat", cd, 0);

    // Same-cycle conflict: data store wins, fetch sees the new word one cycle later
    run_req(1, 32'h10, 1, 4'hF, 32'h10, 32'h0BADF00D, 0, ci, cd);
    check_lat("conflict_data_lat", cd, 0);
    check_lat("conflict_inst_lat", ci, 1);

    // Hold in DONE for 5 cycles, then a fresh request
    run_req(0, 0, 1, 4'h0, 32'h400, 0, 5, ci, cd);
    run_req(0, 0, 1, 4'h0, 32'h8, 0, 0, ci, cd);
    check_lat("after_hold_lat", cd, 0);

    // Flush: enable drops during WAIT, the write must still commit
    model[midx(32'h30)] = 32'h55AA55AA;
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h30; data_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    data_en = 1'b0;
    @(negedge clk);
    check_eq("flush_stall", data_stall, 0);
    repeat (8) @(posedge clk);
    #1;
    run_req(0, 0, 1, 4'h0, 32'h30, 0, 0, ci, cd);

    // Reset mid-WAIT of a write: outputs clear, word unchanged
    run_req(0, 0, 1, 4'hF, 32'h20, 32'h11112222, 0, ci, cd);
    run_req(0, 0, 1, 4'h0, 32'h8, 0, 0, ci, cd);
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h20; data_wdata = 32'hFFFFFFFF;
    @(posedge clk); #2;
    rst = 1'b1;
    data_en = 1'b0;
    #1;
    check_eq("arst_inst_rdata", inst_rdata, 32'h0);
    check_eq("arst_data_rdata", data_rdata, 32'h0);
    check_eq("arst_data_stall", data_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(0, 0, 1, 4'h0, 32'h20, 0, 0, ci, cd);

    // Random reads, alternating ports, with ignored address bits set
    for (int i = 0; i < 8; i++)
      run_req(0, 0, 1, 4'hF, 32'h40 + 32'(4 * i), $urandom, 0, ci, cd);
    for (int i = 0; i < 100; i++) begin
      a = (32'h40 + 32'(4 * $urandom_range(0, 7))) | ($urandom & 32'hFFFFC000) | ($urandom & 32'h3);
      if (i % 2 == 0) begin
        run_req(1, a, 0, 4'h0, 0, 0, 0, ci, cd);
        check_lat("rand_inst_lat", ci, 0);
      end else begin
        run_req(0, 0, 1, 4'h0, a, 0, 0, ci, cd);
        check_lat("rand_data_lat", cd, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_like_mem_responder.md
Name: sram_like_mem_responder

Overview:
- Memory-side responder for the core's split instruction/data request interface: enables, addresses, write strobes and write data.
- Returns read data and drives instrStall/dataStall until each request completes.
- Models a word-addressed RAM with configurable access latency and a single shared array port.
- Holds each completed result until the core's longest_stall drops, so the early-finishing port is not re-issued.

Parameters:
- ADDR_W, 12, word-address width; array holds 2^ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2].
- LATENCY, 2, cycles from request capture to array access; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- inst_en  input  1  instruction fetch request (instr_enF)
- inst_addr  input  32  fetch address (pcF)
- inst_rdata  output  32  fetched word (instrF)
- inst_stall  output  1  fetch not complete (instrStall)
- data_en  input  1  data request (mem_enM)
- data_wen  input  4  byte write strobes; 0 = read (mem_wenM)
- data_addr  input  32  data address (aluoutM)
- data_wdata  input  32  store data (mem_write_dataM)
- data_rdata  output  32  load data (readdataM)
- data_stall  output  1  data access not complete (dataStall)
- longest_stall  input  1  core-wide pipeline stall; high = core not advancing

Behaviour:
- Reset values:
  - Both port FSMs go to IDLE and all counters clear.
  - inst_rdata and data_rdata = 0.
  - Array contents are not reset.
- Per-port FSM, identical for instruction and data ports.
- IDLE:
  - On en=1, capture addr (plus wen/wdata on the data port), load counter with LATENCY, go to WAIT.
  - en=0: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0 and the array port is granted this cycle:
    - A read registers rdata.
    - A write applies byte lanes where wen[i]=1 to bits [8i+7:8i].
    - Go to DONE.
  - Not granted: stay in WAIT with counter at 0.
- DONE:
  - rdata holds.
  - Stay while longest_stall=1.
  - When longest_stall=0, go to IDLE on the next edge.
- Stall (combinational):
  - stall = en & (state != DONE).
  - Asserts in the same cycle as a new en with no registered delay.
- Minimum latency: a request raised in cycle 0 with LATENCY=L and no conflict deasserts stall in cycle L+1.
- Arbitration:
  - One array access per cycle.
  - If both ports reach counter 0 in the same cycle, the data port wins and the instruction port accesses next cycle.
- Data write followed by an instruction read of the same word in the same conflict cycle: the instruction port sees the new value, because data goes first.
- en dropping during WAIT (flush): the request is still completed (writes still committed), then the FSM returns to IDLE through DONE. stall reads 0 because en=0.
- Address bits above ADDR_W+1 and bits [1:0] are ignored.
- Asynchronous reset mid-WAIT:
  - The pending access is abandoned.
  - No write is committed unless the array access edge already occurred.

Optional Feature:
- Macro: SRAM_LIKE_RESP_RAND_LAT_EN.
- Defined:
  - A 16-bit LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) steps every cycle.
  - On each capture in IDLE, LFSR[1:0] is added to LATENCY for that request (extra 0..3 cycles), applied independently per port.
- Undefined: latency is exactly LATENCY. LFSR logic is absent.

Test Plan:
- Single read:
  - Stimulus: preload word 0x100 = 32'hDEADBEEF; LATENCY=2; inst_en=1, addr 32'h00000400 at cycle 0; longest_stall=inst_stall.
  - Required: inst_stall=1 in cycles 0-2, 0 in cycle 3; inst_rdata=32'hDEADBEEF from cycle 3.
- Byte write:
  - Stimulus: data_en=1, wen=4'b0011, addr 32'h8, wdata 32'h12345678, over old 32'hAAAAAAAA.
  - Required: a later read of 0x8 returns 32'hAAAA5678.
- Conflict:
  - Stimulus: both ports request in the same cycle, data store 32'h0BADF00D to addr 32'h10, fetch from 32'h10.
  - Required: data_stall drops at cycle 3; inst_stall drops at cycle 4 with inst_rdata=32'h0BADF00D.
- Hold:
  - Stimulus: after the data port reaches DONE, keep longest_stall=1 for 5 cycles.
  - Required: data_stall=0 and data_rdata stable throughout, with no second access; one new request is accepted after longest_stall falls.
- Reset:
  - Stimulus: assert rst mid-WAIT of a write to 32'h20.
  - Required: outputs 0 immediately; word 0x20 unchanged.
- Macro:
  - Stimulus: SRAM_LIKE_RESP_RAND_LAT_EN defined, 100 reads.
  - Required: every stall duration lies in LATENCY+1..LATENCY+4 cycles, and the data is correct.
